// File: rtl/nch_fifo_rdctl.sv
// N-channel read controller for the front-end data FIFOs: issues latency-tolerant
// active-low reads per channel and buffers returned words in a small prefetch queue.
module nch_fifo_rdctl #(
    parameter int unsigned NCH    = 6,
    parameter int unsigned DW     = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              init_,
    input  logic [NCH-1:0]    en,
    input  logic              lockstep,
    input  logic [NCH-1:0]    ef_,
    output logic [NCH-1:0]    rden_,
    input  logic [NCH*DW-1:0] din,
    output logic [NCH-1:0]    reg_en,
    output logic [NCH*DW-1:0] dout,
    output logic [NCH-1:0]    pok,
    input  logic [NCH-1:0]    pop,
    output logic              pok_all,
    input  logic              pop_all,
    output logic [NCH-1:0]    err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam int unsigned FW = $clog2(RD_LAT + 1);
    localparam int unsigned SW = OW + FW;

    logic [DW-1:0]     mem_q  [NCH][DEPTH];
    logic [AW-1:0]     wptr_q [NCH];
    logic [AW-1:0]     rptr_q [NCH];
    logic [OW-1:0]     occ_q  [NCH];
    logic [RD_LAT-1:0] vsr_q  [NCH];
    logic [RD_LAT-1:0] vsr_d  [NCH];
    logic [NCH-1:0]    err_q;

    logic [FW-1:0]  infl [NCH];
    logic [NCH-1:0] nonempty;
    logic [NCH-1:0] rd;
    logic [NCH-1:0] cap;
    logic [NCH-1:0] pop_ok;
    logic [NCH-1:0] err_set;

    // Issue decision counts reads still in the latency pipe against free queue slots.
    always_comb begin
        nonempty = '0;
        rd       = '0;
        cap      = '0;
        for (int i = 0; i < NCH; i++) begin
            infl[i] = '0;
            for (int k = 0; k < RD_LAT; k++) begin
                infl[i] = infl[i] + FW'(vsr_q[i][k]);
            end
            nonempty[i] = (occ_q[i] != '0);
            rd[i]       = init_ && en[i] && ef_[i] &&
                          ((SW'(occ_q[i]) + SW'(infl[i])) < SW'(DEPTH));
            cap[i]      = vsr_q[i][RD_LAT-1];
            vsr_d[i]    = '0;
            vsr_d[i][0] = rd[i];
            for (int k = 1; k < RD_LAT; k++) begin
                vsr_d[i][k] = vsr_q[i][k-1];
            end
        end
    end

    always_comb begin
        pok_all = (en != '0) && (&(~en | nonempty));
        if (lockstep) begin
            pok     = en & {NCH{pok_all}};
            pop_ok  = en & {NCH{pop_all && pok_all}};
            err_set = en & {NCH{pop_all && !pok_all}};
        end else begin
            pok     = en & nonempty;
            pop_ok  = pop & pok;
            err_set = pop & ~pok;
        end
        rden_  = ~rd;
        reg_en = cap & {NCH{init_}};
        err    = err_q;
        dout   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (nonempty[i]) begin
                dout[i*DW +: DW] = mem_q[i][rptr_q[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!init_) begin
            err_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                occ_q[i]  <= '0;
                vsr_q[i]  <= '0;
            end
        end else begin
            err_q <= err_q | err_set;
            for (int i = 0; i < NCH; i++) begin
                vsr_q[i] <= vsr_d[i];
                if (cap[i]) begin
                    mem_q[i][wptr_q[i]] <= din[i*DW +: DW];
                    wptr_q[i]           <= wptr_q[i] + AW'(1);
                end
                if (pop_ok[i]) begin
                    rptr_q[i] <= rptr_q[i] + AW'(1);
                end
                occ_q[i] <= occ_q[i] + OW'(cap[i]) - OW'(pop_ok[i]);
            end
        end
    end

endmodule
